// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU-control issue stage: main-control op classes,
// R-type funct codes and the 4-bit control codes the ALU decodes.
package alu_ctrl_pkg;

   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_RTYPE = 3'b010;
   localparam logic [2:0] ALUOP_AND   = 3'b011;
   localparam logic [2:0] ALUOP_OR    = 3'b100;
   localparam logic [2:0] ALUOP_SLT   = 3'b101;
   localparam logic [2:0] ALUOP_LI    = 3'b110;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_MUL = 6'b011000;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;

   localparam logic [3:0] CTRL_AND     = 4'b0000;
   localparam logic [3:0] CTRL_OR      = 4'b0001;
   localparam logic [3:0] CTRL_ADD     = 4'b0010;
   localparam logic [3:0] CTRL_MUL     = 4'b0011;
   localparam logic [3:0] CTRL_LI      = 4'b0100;
   localparam logic [3:0] CTRL_SUB     = 4'b0110;
   localparam logic [3:0] CTRL_SLT     = 4'b0111;
   localparam logic [3:0] CTRL_NOR     = 4'b1100;
   localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

   typedef struct packed {
      logic [3:0] ctrl;
      logic       illegal;
   } ctrl_dec_t;

   // Anything not explicitly listed (aluop 111, unknown funct) maps to ILLEGAL.
   function automatic ctrl_dec_t decode_ctrl(input logic [2:0] aluop,
                                             input logic [5:0] funct);
      ctrl_dec_t dec;
      dec.ctrl    = CTRL_ILLEGAL;
      dec.illegal = 1'b1;
      case (aluop)
         ALUOP_ADD: dec = '{ctrl: CTRL_ADD, illegal: 1'b0};
         ALUOP_SUB: dec = '{ctrl: CTRL_SUB, illegal: 1'b0};
         ALUOP_AND: dec = '{ctrl: CTRL_AND, illegal: 1'b0};
         ALUOP_OR:  dec = '{ctrl: CTRL_OR,  illegal: 1'b0};
         ALUOP_SLT: dec = '{ctrl: CTRL_SLT, illegal: 1'b0};
         ALUOP_LI:  dec = '{ctrl: CTRL_LI,  illegal: 1'b0};
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD: dec = '{ctrl: CTRL_ADD, illegal: 1'b0};
               FUNCT_SUB: dec = '{ctrl: CTRL_SUB, illegal: 1'b0};
               FUNCT_AND: dec = '{ctrl: CTRL_AND, illegal: 1'b0};
               FUNCT_OR:  dec = '{ctrl: CTRL_OR,  illegal: 1'b0};
               FUNCT_SLT: dec = '{ctrl: CTRL_SLT, illegal: 1'b0};
               FUNCT_MUL: dec = '{ctrl: CTRL_MUL, illegal: 1'b0};
               FUNCT_NOR: dec = '{ctrl: CTRL_NOR, illegal: 1'b0};
               default:   dec = '{ctrl: CTRL_ILLEGAL, illegal: 1'b1};
            endcase
         end
         default: dec = '{ctrl: CTRL_ILLEGAL, illegal: 1'b1};
      endcase
      return dec;
   endfunction

endpackage

// File: rtl/alu_ctrl_issue_if.sv
// Decode-side and execute-side handshake/data bundle for the ALU issue stage.
interface alu_ctrl_issue_if #(parameter int DATA_W = 32);

   logic              in_valid_i;
   logic              in_ready_o;
   logic [2:0]        aluop_i;
   logic [5:0]        funct_i;
   logic              alusrc_i;
   logic [DATA_W-1:0] src1_i;
   logic [DATA_W-1:0] src2_i;
   logic [DATA_W-1:0] imm_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [3:0]        ctrl_o;
   logic [DATA_W-1:0] src1_o;
   logic [DATA_W-1:0] src2_o;
   logic              illegal_o;

   modport master (
      output in_valid_i, aluop_i, funct_i, alusrc_i, src1_i, src2_i, imm_i, out_ready_i,
      input  in_ready_o, out_valid_o, ctrl_o, src1_o, src2_o, illegal_o
   );

   modport slave (
      input  in_valid_i, aluop_i, funct_i, alusrc_i, src1_i, src2_i, imm_i, out_ready_i,
      output in_ready_o, out_valid_o, ctrl_o, src1_o, src2_o, illegal_o
   );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU-control decode: op class/funct to control code, plus
// operand selection (li takes its first operand from the immediate).
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        aluop,
   input  logic [5:0]        funct,
   input  logic              alusrc,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   input  logic [DATA_W-1:0] imm,
   output logic [3:0]        ctrl,
   output logic [DATA_W-1:0] op1,
   output logic [DATA_W-1:0] op2,
   output logic              illegal
);

   ctrl_dec_t dec;

   // Illegal ops still carry their operands through untouched.
   always_comb begin
      dec     = decode_ctrl(aluop, funct);
      ctrl    = dec.ctrl;
      illegal = dec.illegal;
      op1     = (aluop == ALUOP_LI) ? imm : src1;
      op2     = alusrc ? imm : src2;
   end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ALU issue stage: decodes ops at push time and holds them in a 2-entry
// valid/ready skid buffer so decode never sees execute's ready combinationally.
module alu_ctrl_issue
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   alu_ctrl_issue_if.slave  bus
);

   logic [3:0]        ctrl_q    [DEPTH];
   logic [DATA_W-1:0] src1_q    [DEPTH];
   logic [DATA_W-1:0] src2_q    [DEPTH];
   logic              illegal_q [DEPTH];

   logic [1:0] count;
   logic       wr_ptr;
   logic       rd_ptr;
   logic       push;
   logic       pop;

   logic [3:0]        dec_ctrl;
   logic [DATA_W-1:0] dec_op1;
   logic [DATA_W-1:0] dec_op2;
   logic              dec_illegal;

   alu_ctrl_decode #(.DATA_W(DATA_W)) u_decode (
      .aluop   (bus.aluop_i),
      .funct   (bus.funct_i),
      .alusrc  (bus.alusrc_i),
      .src1    (bus.src1_i),
      .src2    (bus.src2_i),
      .imm     (bus.imm_i),
      .ctrl    (dec_ctrl),
      .op1     (dec_op1),
      .op2     (dec_op2),
      .illegal (dec_illegal)
   );

   // Ready comes only from the occupancy register, never from out_ready_i.
   assign bus.in_ready_o  = (count < 2'd2);
   assign bus.out_valid_o = (count != 2'd0);
   assign push            = bus.in_valid_i & bus.in_ready_o;
   assign pop             = bus.out_valid_o & bus.out_ready_i;

   assign bus.ctrl_o    = ctrl_q[rd_ptr];
   assign bus.src1_o    = src1_q[rd_ptr];
   assign bus.src2_o    = src2_q[rd_ptr];
   assign bus.illegal_o = illegal_q[rd_ptr];

   // Reset beats flush, flush beats push/pop; payload is left stale on flush.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            ctrl_q[i]    <= CTRL_AND;
            src1_q[i]    <= '0;
            src2_q[i]    <= '0;
            illegal_q[i] <= 1'b0;
         end
      end else if (flush_i) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            ctrl_q[wr_ptr]    <= dec_ctrl;
            src1_q[wr_ptr]    <= dec_op1;
            src2_q[wr_ptr]    <= dec_op2;
            illegal_q[wr_ptr] <= dec_illegal;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Self-checking bench for alu_ctrl_issue: directed steps followed by random
// traffic, compared against a queue-based reference model.
module tb_alu_ctrl_issue;

   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   always #5 clk = ~clk;

   alu_ctrl_issue_if #(.DATA_W(DATA_W)) bus ();

   alu_ctrl_issue #(.DATA_W(DATA_W), .DEPTH(2)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .bus     (bus)
   );

   typedef struct {
      int          ctrl;
      logic [31:0] s1;
      logic [31:0] s2;
      bit          ill;
   } exp_t;

   exp_t model_q[$];
   int   checks = 0;
   int   fails  = 0;

   // Control code per op class; -1 means "look at funct", 15 means illegal.
   int op_ctrl [8] = '{2, 6, -1, 0, 1, 7, 4, 15};
   int funct_ctrl [int];

   function automatic exp_t reference(input logic [2:0] aluop, input logic [5:0] funct,
                                      input logic alusrc, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [31:0] imm);
      exp_t e;
      e.ctrl = op_ctrl[aluop];
      if (e.ctrl == -1)
         e.ctrl = funct_ctrl.exists(int'(funct)) ? funct_ctrl[int'(funct)] : 15;
      e.ill = (e.ctrl == 15);
      e.s1  = (aluop == 3'd6) ? imm : s1;
      e.s2  = alusrc ? imm : s2;
      return e;
   endfunction

   task automatic checkValue(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string where);
      checkValue({where, " in_ready"},  32'(bus.in_ready_o),  32'(model_q.size() < 2));
      checkValue({where, " out_valid"}, 32'(bus.out_valid_o), 32'(model_q.size() != 0));
      if (model_q.size() != 0) begin
         checkValue({where, " ctrl"},    32'(bus.ctrl_o),    32'(model_q[0].ctrl));
         checkValue({where, " src1"},    bus.src1_o,         model_q[0].s1);
         checkValue({where, " src2"},    bus.src2_o,         model_q[0].s2);
         checkValue({where, " illegal"}, 32'(bus.illegal_o), 32'(model_q[0].ill));
      end
   endtask

   task automatic applyStimulus(input bit valid, input logic [2:0] aluop,
                                input logic [5:0] funct, input bit alusrc,
                                input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] imm, input bit ordy, input bit fl);
      bus.in_valid_i  = valid;
      bus.aluop_i     = aluop;
      bus.funct_i     = funct;
      bus.alusrc_i    = alusrc;
      bus.src1_i      = s1;
      bus.src2_i      = s2;
      bus.imm_i       = imm;
      bus.out_ready_i = ordy;
      flush           = fl;
   endtask

   // Reference behaviour at a clock edge, using the model's own occupancy.
   task automatic modelEdge();
      bit accept;
      bit consume;
      if (rst || flush) begin
         model_q.delete();
      end else begin
         accept  = bus.in_valid_i && (model_q.size() < 2);
         consume = (model_q.size() != 0) && bus.out_ready_i;
         if (consume) void'(model_q.pop_front());
         if (accept)
            model_q.push_back(reference(bus.aluop_i, bus.funct_i, bus.alusrc_i,
                                        bus.src1_i, bus.src2_i, bus.imm_i));
      end
   endtask

   task automatic step(input string where, input bit valid, input logic [2:0] aluop,
                       input logic [5:0] funct, input bit alusrc, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [31:0] imm, input bit ordy,
                       input bit fl);
      applyStimulus(valid, aluop, funct, alusrc, s1, s2, imm, ordy, fl);
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkOutput(where);
   endtask

   // Directed scenarios first, then random traffic including flush and reset.
   initial begin
      logic [5:0] funct_pick [8];
      funct_ctrl[32] = 2;  funct_ctrl[34] = 6;  funct_ctrl[36] = 0;  funct_ctrl[37] = 1;
      funct_ctrl[42] = 7;  funct_ctrl[24] = 3;  funct_ctrl[39] = 12;
      funct_pick = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd24, 6'd39, 6'd0};

      rst = 1'b1;
      applyStimulus(0, 3'd0, 6'd0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      step("rst0", 0, 3'd0, 6'd0, 0, 0, 0, 0, 0, 0);
      step("rst1", 0, 3'd0, 6'd0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      checkValue("reset ctrl",    32'(bus.ctrl_o),    32'h0);
      checkValue("reset src1",    bus.src1_o,         32'h0);
      checkValue("reset src2",    bus.src2_o,         32'h0);
      checkValue("reset illegal", 32'(bus.illegal_o), 32'h0);

      step("slt push",  1, 3'b010, 6'b101010, 0, 32'd5, 32'd9, 32'h0, 1, 0);
      step("slt drain", 0, 3'b000, 6'd0,      0, 32'd0, 32'd0, 32'h0, 1, 0);

      step("addi",  1, 3'b000, 6'd0, 1, 32'd3, 32'd7, 32'hFFFF_FFFC, 1, 0);
      step("li",    1, 3'b110, 6'd0, 0, 32'hAAAA, 32'd1, 32'h1234, 1, 0);
      step("li drain", 0, 3'b000, 6'd0, 0, 0, 0, 0, 1, 0);

      step("full add",  1, 3'b000, 6'd0, 0, 32'd1, 32'd2, 32'd0, 0, 0);
      step("full sub",  1, 3'b001, 6'd0, 0, 32'd3, 32'd4, 32'd0, 0, 0);
      step("full or",   1, 3'b100, 6'd0, 0, 32'd5, 32'd6, 32'd0, 0, 0);
      step("pop add",   0, 3'b000, 6'd0, 0, 0, 0, 0, 1, 0);
      step("pop sub",   0, 3'b000, 6'd0, 0, 0, 0, 0, 1, 0);
      step("re or",     1, 3'b100, 6'd0, 0, 32'd5, 32'd6, 32'd0, 1, 0);
      step("or drain",  0, 3'b000, 6'd0, 0, 0, 0, 0, 1, 0);

      step("fl fill0",  1, 3'b011, 6'd0, 1, 32'd8, 32'd9, 32'h77, 0, 0);
      step("fl fill1",  1, 3'b101, 6'd0, 0, 32'd8, 32'd9, 32'h77, 0, 0);
      step("flush",     1, 3'b000, 6'd0, 0, 32'd1, 32'd1, 32'd1, 0, 1);
      step("post flush", 0, 3'b000, 6'd0, 0, 0, 0, 0, 1, 0);

      step("rs fill0",  1, 3'b000, 6'd0, 0, 32'd11, 32'd12, 32'd0, 0, 0);
      step("rs fill1",  1, 3'b001, 6'd0, 0, 32'd13, 32'd14, 32'd0, 0, 0);
      rst = 1'b1;
      step("mid reset", 0, 3'b000, 6'd0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      step("ill nor?",  1, 3'b010, 6'b000111, 0, 32'd21, 32'd22, 32'd0, 0, 0);
      step("ill op7",   1, 3'b111, 6'b100000, 1, 32'd23, 32'd24, 32'h99, 0, 0);
      step("ill pop0",  0, 3'b000, 6'd0, 0, 0, 0, 0, 1, 0);
      step("legal",     1, 3'b000, 6'd0, 0, 32'd25, 32'd26, 32'd0, 1, 0);
      step("legal out", 0, 3'b000, 6'd0, 0, 0, 0, 0, 1, 0);
      step("idle",      0, 3'b000, 6'd0, 0, 0, 0, 0, 1, 0);

      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(99) == 0);
         step("rand", $urandom_range(3) != 0, 3'($urandom_range(7)),
              ($urandom_range(5) == 0) ? 6'($urandom) : funct_pick[$urandom_range(6)],
              1'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(2) != 0, $urandom_range(19) == 0);
      end
      rst = 1'b0;
      step("final", 0, 3'b000, 6'd0, 0, 0, 0, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
